// File: rtl/bar_counter_pkg.sv
// bar_counter_pkg
//   Shared types and constants for the bar_counter level source.
//   - state_e     : level-control state machine encoding
//   - LEVEL_W     : width of the level bus into the display stage
//   - *_DEF       : default parameter values for the top and sub-module
//   - cnt_width() : counter width for a 0..n-1 counter (never below 1)
package bar_counter_pkg;

  localparam int LEVEL_W         = 5;
  localparam int MAX_COUNT_DEF   = 16;
  localparam int DB_CYCLES_DEF   = 500000;
  localparam int TICK_CYCLES_DEF = 25000000;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    AUTO_UP   = 2'd1,
    AUTO_DOWN = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bar_counter_btn_conditioner.sv
// btn_conditioner
//   Turns one raw push-button into a single-cycle press pulse:
//   2-FF synchroniser -> optional debounce filter -> rising-edge detect.
//   Optional feature macro: BAR_COUNTER_DEBOUNCE_EN (compiles in the filter;
//   without it the debounced level is the synchronised level and DB_CYCLES
//   is unused).
// Ports
//   clk     in   system clock
//   rst     in   async active-high reset
//   btn_raw in   asynchronous raw button level
//   press   out  one-cycle pulse on each debounced rising edge
module btn_conditioner
  import bar_counter_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  logic [1:0] sync_q, sync_d;
  logic       edge_q, edge_d;
  logic       lvl;

  always_comb begin
    sync_d = {sync_q[0], btn_raw};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

`ifdef BAR_COUNTER_DEBOUNCE_EN
  localparam int DB_W = cnt_width(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_lvl_q, db_lvl_d;

  // The level only flips after DB_CYCLES consecutive disagreeing cycles;
  // a single agreeing cycle restarts the count.
  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    if (sync_q[1] != db_lvl_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_lvl_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q <= '0;
      db_lvl_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_lvl_q <= db_lvl_d;
    end
  end

  assign lvl = db_lvl_q;
`else
  assign lvl = sync_q[1];
`endif

  always_comb begin
    edge_d = lvl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) edge_q <= 1'b0;
    else     edge_q <= edge_d;
  end

  assign press = lvl & ~edge_q;

endmodule

// File: rtl/bar_counter.sv
// bar_counter
//   Saturating 0..MAX_COUNT level source for the 16-LED thermometer bar,
//   with push-button control and an auto up/down sweep on a prescaled tick.
//   Optional feature macro: BAR_COUNTER_DEBOUNCE_EN (button debounce filter,
//   applied inside btn_conditioner; auto_en is only synchronised).
// Ports
//   clk         in   system clock
//   rst         in   async active-high reset
//   btn_up      in   raw button, increment
//   btn_down    in   raw button, decrement
//   btn_clear   in   raw button, clear to 0
//   auto_en     in   raw level switch, 1 selects auto sweep
//   counter_out out  current level 0..MAX_COUNT (5 bits)
//   at_max      out  counter_out == MAX_COUNT
//   at_min      out  counter_out == 0
//   dir_up      out  sweep direction, 0 only in AUTO_DOWN
//
// state     | meaning
// ----------+---------------------------------------------------
// MANUAL    | buttons step the level; prescaler held at 0
// AUTO_UP   | level +1 per tick; reaching MAX_COUNT turns down
// AUTO_DOWN | level -1 per tick; reaching 0 turns up
module bar_counter
  import bar_counter_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int MAX_COUNT   = MAX_COUNT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_clear,
  input  logic               auto_en,
  output logic [LEVEL_W-1:0] counter_out,
  output logic               at_max,
  output logic               at_min,
  output logic               dir_up
);

  localparam int PRESC_W = cnt_width(TICK_CYCLES);
  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(MAX_COUNT);
  localparam logic [LEVEL_W-1:0] LVL_ONE   = LEVEL_W'(1);

  logic up_press, down_press, clr_press;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond_up (
    .clk(clk), .rst(rst), .btn_raw(btn_up), .press(up_press)
  );
  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond_down (
    .clk(clk), .rst(rst), .btn_raw(btn_down), .press(down_press)
  );
  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond_clr (
    .clk(clk), .rst(rst), .btn_raw(btn_clear), .press(clr_press)
  );

  logic [1:0]         auto_sync_q, auto_sync_d;
  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               auto_on;
  logic               tick;

  assign auto_on = auto_sync_q[1];
  assign tick    = (presc_q == TICK_LAST);

  always_comb begin
    auto_sync_d = {auto_sync_q[0], auto_en};
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    presc_d = presc_q;
    case (state_q)
      MANUAL: begin
        presc_d = '0;
        if (auto_on) begin
          state_d = (level_q == LVL_MAX) ? AUTO_DOWN : AUTO_UP;
        end else if (clr_press) begin
          level_d = '0;
        end else if (up_press && down_press) begin
          level_d = level_q;
        end else if (up_press) begin
          if (level_q != LVL_MAX) level_d = level_q + LVL_ONE;
        end else if (down_press) begin
          if (level_q != '0) level_d = level_q - LVL_ONE;
        end
      end
      AUTO_UP, AUTO_DOWN: begin
        // Exit outranks clear and tick: a tick in the exit cycle is dropped.
        if (!auto_on) begin
          state_d = MANUAL;
          presc_d = '0;
        end else if (clr_press) begin
          level_d = '0;
          state_d = AUTO_UP;
          presc_d = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (state_q == AUTO_UP) begin
              if (level_q != LVL_MAX) level_d = level_q + LVL_ONE;
              if (level_q + LVL_ONE >= LVL_MAX) state_d = AUTO_DOWN;
            end else begin
              if (level_q != '0) level_d = level_q - LVL_ONE;
              if (level_q <= LVL_ONE) state_d = AUTO_UP;
            end
          end
        end
      end
      default: begin
        state_d = MANUAL;
        presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_sync_q <= '0;
      state_q     <= MANUAL;
      level_q     <= '0;
      presc_q     <= '0;
    end else begin
      auto_sync_q <= auto_sync_d;
      state_q     <= state_d;
      level_q     <= level_d;
      presc_q     <= presc_d;
    end
  end

  assign counter_out = level_q;
  assign at_max      = (level_q == LVL_MAX);
  assign at_min      = (level_q == '0);
  assign dir_up      = (state_q != AUTO_DOWN);

endmodule

// File: tb/tb_bar_counter.sv
module tb_bar_counter;

  localparam int TICK = 8;
  localparam int MAXC = 16;
`ifdef BAR_COUNTER_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_clear = 1'b0, auto_en = 1'b0;
  logic [4:0] counter_out;
  logic       at_max, at_min, dir_up;

  int n_cmp = 0;
  int n_err = 0;
  int exp_lvl;
  int m_lvl;
  int m_dir;

  bar_counter #(.DB_CYCLES(4), .TICK_CYCLES(TICK), .MAX_COUNT(MAXC)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_clear(btn_clear),
    .auto_en(auto_en),
    .counter_out(counter_out), .at_max(at_max), .at_min(at_min), .dir_up(dir_up)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clean press: held long enough to pass the filter, then released and settled.
  task automatic press(input logic u, input logic d, input logic c);
    btn_up = u; btn_down = d; btn_clear = c;
    step_clk(DB + 2);
    btn_up = 1'b0; btn_down = 1'b0; btn_clear = 1'b0;
    step_clk(DB + 4);
  endtask

  // One auto tick period from a tick edge: level holds 7 cycles, moves on the 8th.
  task automatic auto_step;
    step_clk(TICK - 1);
    check("auto_hold", counter_out, m_lvl);
    if (m_dir == 1) begin
      m_lvl++;
      if (m_lvl == MAXC) m_dir = 0;
    end else begin
      m_lvl--;
      if (m_lvl == 0) m_dir = 1;
    end
    step_clk(1);
    check("auto_lvl", counter_out, m_lvl);
    check("auto_dir", dir_up, m_dir);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt", counter_out, 0);
    check("rst_min", at_min, 1);
    check("rst_max", at_max, 0);
    check("rst_dir", dir_up, 1);
    rst = 1'b0;
    step_clk(2);

    exp_lvl = 0;
    for (int i = 0; i < 17; i++) begin
      press(1'b1, 1'b0, 1'b0);
      exp_lvl = (exp_lvl < MAXC) ? exp_lvl + 1 : MAXC;
      check("up_sat", counter_out, exp_lvl);
    end
    check("at_max16", at_max, 1);
    check("at_min16", at_min, 0);
    press(1'b1, 1'b0, 1'b0);
    check("up_hold16", counter_out, 16);

    press(1'b0, 1'b0, 1'b1);
    check("clear", counter_out, 0);
    check("at_min0", at_min, 1);

`ifdef BAR_COUNTER_DEBOUNCE_EN
    btn_up = 1'b1;
    step_clk(3);
    btn_up = 1'b0;
    step_clk(12);
    check("glitch3", counter_out, 0);
    btn_up = 1'b1;
    step_clk(6);
    check("hold6_before", counter_out, 0);
    btn_up = 1'b0;
    step_clk(1);
    check("hold6_at", counter_out, 1);
    step_clk(12);
    check("hold6_release", counter_out, 1);
`else
    btn_up = 1'b1;
    step_clk(1);
    btn_up = 1'b0;
    step_clk(1);
    check("pulse1_before", counter_out, 0);
    step_clk(1);
    check("pulse1_at", counter_out, 1);
    step_clk(6);
    check("pulse1_after", counter_out, 1);
`endif

    btn_up = 1'b1;
    step_clk(20);
    check("held_once", counter_out, 2);
    btn_up = 1'b0;
    step_clk(12);
    check("release_none", counter_out, 2);

    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0);
    check("to5", counter_out, 5);
    press(1'b1, 1'b1, 1'b0);
    check("up_down", counter_out, 5);
    press(1'b0, 1'b1, 1'b0);
    check("down", counter_out, 4);
    press(1'b1, 1'b0, 1'b1);
    check("clr_up", counter_out, 0);
    press(1'b0, 1'b1, 1'b0);
    check("down_sat0", counter_out, 0);

    for (int i = 0; i < 14; i++) press(1'b1, 1'b0, 1'b0);
    check("to14", counter_out, 14);

    auto_en = 1'b1;
    step_clk(3);
    check("auto_entry_lvl", counter_out, 14);
    check("auto_entry_dir", dir_up, 1);
    m_lvl = 14;
    m_dir = 1;
    for (int i = 0; i < 19; i++) auto_step();
    check("sweep_end", counter_out, 1);

    for (int i = 0; i < 40 && !(m_lvl == 9 && m_dir == 0); i++) auto_step();
    check("at9_down", dir_up, 0);
    btn_clear = 1'b1;
    step_clk(3 + DB);
    check("auto_clr_lvl", counter_out, 0);
    check("auto_clr_dir", dir_up, 1);
    btn_clear = 1'b0;
    m_lvl = 0;
    m_dir = 1;
    for (int i = 0; i < 3; i++) auto_step();

    auto_en = 1'b0;
    step_clk(3);
    check("exit_lvl", counter_out, 3);
    step_clk(20);
    check("manual_hold", counter_out, 3);
    check("manual_dir", dir_up, 1);

    auto_en = 1'b1;
    step_clk(3 + 2 * TICK);
    check("resweep", counter_out, 5);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_cnt", counter_out, 0);
    check("async_rst_min", at_min, 1);
    check("async_rst_dir", dir_up, 1);
    auto_en = 1'b0;
    step_clk(2);
    rst = 1'b0;
    step_clk(4);
    check("post_rst", counter_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
